ysyx_25020047_idu_stage: RTL
============================

// Module: ysyx_25020047_idu_stage
// PURPOSE
//  Registered, handshaked RV32I decode stage; successor to the combinational I-type field splitter.
//  Sits between IFU and EXU: accepts {pc, inst}, extracts all fields, builds the sign-extended
//  immediate for every format and classifies the format.
//  2-entry skid buffer decouples IFU from EXU backpressure at full throughput.
// PARAMETERS
//  XLEN      32  datapath width of pc and imm (>=32; imm sign-extended to XLEN)
//  RA_W      5   register-index width (4 = RV32E: index MSB must be 0, else illegal)
//  DEPTH     2   skid buffer entries (legal 1..4); DEPTH=1 drops throughput to 1 inst/2 clk
// PORTS
//  clk          in   1      clock, rising edge
//  rst_n        in   1      async active-low reset
//  flush        in   1      sync discard of all buffered entries (redirect)
//  in_valid     in   1      IFU offers {in_pc,in_inst}
//  in_ready     out  1      stage can accept this cycle
//  in_pc        in   XLEN   instruction address
//  in_inst      in   32     raw instruction
//  out_valid    out  1      head entry valid
//  out_ready    in   1      EXU consumes head
//  out_pc       out  XLEN   pc of head
//  out_opcode   out  7      inst[6:0]
//  out_funct3   out  3      inst[14:12]
//  out_funct7   out  7      inst[31:25]
//  out_rs1      out  RA_W   inst[15+:RA_W]
//  out_rs2      out  RA_W   inst[20+:RA_W]
//  out_rd       out  RA_W   inst[7+:RA_W]
//  out_imm      out  XLEN   sign-extended immediate for decoded format (0 for R/N)
//  out_fmt      out  3      0=R 1=I 2=S 3=B 4=U 5=J 7=N(unknown)
//  out_illegal  out  1      illegal-instruction flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: count=0, rd/wr ptrs=0, out_valid=0, in_ready=1, all data outputs 0.
//  - Accept on in_valid&&in_ready; pop on out_valid&&out_ready. Decode done combinationally at
//    input, result written into buffer entry -> latency exactly 1 clk (accept at N, out_valid at N+1).
//  - in_ready = (count<DEPTH), registered-equivalent: depends only on state, never on out_ready.
//  - Simultaneous push+pop when full: push refused (in_ready=0); when not full: count unchanged.
//  - out_* hold stable while out_valid && !out_ready; pointers wrap modulo DEPTH.
//  - fmt by opcode: 0110011->R; 0010011,0000011,1100111,1110011,0001111->I; 0100011->S;
//    1100011->B; 0110111,0010111->U; 1101111->J; else N.
//  - imm: I={{XLEN-12{i[31]}},i[31:20]}; S={..,i[31:25],i[11:7]}; B={..,i[31],i[7],i[30:25],
//    i[11:8],1'b0}; U={..,i[31:12],12'b0}; J={..,i[31],i[19:12],i[20],i[30:21],1'b0}.
//  - flush: next edge count=0, out_valid=0, in_ready=1; an in_valid same cycle is dropped
//    (flush wins). out_ready in a flush cycle ignored.
//  - rst_n asserted mid-operation: all entries lost asynchronously, outputs to reset values.
//  - out_fmt=N or illegal entries still flow through handshake normally (EXU traps).
// CONFIGURATION
//  YSYX_25020047_IDU_ILLEGAL_EN defined: out_illegal=1 when in_inst[1:0]!=2'b11, fmt=N,
//   or RA_W=4 and any used rs1/rs2/rd MSB=1; flag registered with its entry.
//  Not defined: out_illegal tied 0, no checking logic synthesised.
// TESTING
//  1 in 0x00500093 (addi x1,x0,5), out_ready=1 -> next clk fmt=1 rd=1 rs1=0 imm=0x00000005
//  2 0x00112623 (sw x1,12(x2)) -> fmt=2 rs1=2 rs2=1 imm=0x0000000C; 0x123452B7 -> fmt=4 rd=5
//    imm=0x12345000; 0xFFDFF06F (jal x0,-4) -> fmt=5 imm=0xFFFFFFFC
//  3 out_ready=0, push 3 back-to-back -> in_ready=0 after 2nd accept, 3rd held; raise out_ready
//    -> outputs in order with correct pcs, no loss/duplication
//  4 2 entries buffered, flush=1 with in_valid=1 -> next clk out_valid=0, in_ready=1, nothing emitted
//  5 ILLEGAL_EN: inst 0x00000000 -> out_fmt=7, out_illegal=1; without macro out_illegal=0
//  6 rst_n low mid-stream -> out_valid=0 immediately, in_ready=1 after release, random
//    push/pop stream vs reference model: zero mismatches

Source files
------------

// File: rtl/ysyx_25020047_idu_stage.sv
// ysyx_25020047_idu_stage: registered, handshaked RV32I decode stage.
// Decodes {pc, inst} combinationally at the input. It then writes the decoded
// entry into a DEPTH-entry buffer, which decouples the IFU from EXU backpressure.
// The latency is one clock.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   flush                            synchronous discard of all buffered entries
//   in_valid/in_ready, in_pc/in_inst IFU side handshake and payload
//   out_valid/out_ready              EXU side handshake
//   out_pc, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
//   out_imm, out_fmt, out_illegal    decoded head entry
// Optional feature: define YSYX_25020047_IDU_ILLEGAL_EN to enable illegal-instruction
// flagging. Without it, out_illegal is tied to 0.
module ysyx_25020047_idu_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [RA_W-1:0] out_rs1,
  output logic [RA_W-1:0] out_rs2,
  output logic [RA_W-1:0] out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_N = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            dec;
  fmt_e              fmt;
  logic [31:0]       imm32;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;

  // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Format classification and 32-bit immediate assembly.
  always_comb begin
    fmt   = FMT_N;
    imm32 = '0;
    unique case (in_inst[6:0])
      7'b0110011:                                     fmt = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111:                         fmt = FMT_I;
      7'b0100011:                                     fmt = FMT_S;
      7'b1100011:                                     fmt = FMT_B;
      7'b0110111, 7'b0010111:                         fmt = FMT_U;
      7'b1101111:                                     fmt = FMT_J;
      default:                                        fmt = FMT_N;
    endcase
    unique case (fmt)
      FMT_I: imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      FMT_S: imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      FMT_B: imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
      FMT_U: imm32 = {in_inst[31:12], 12'b0};
      FMT_J: imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Decoded entry; imm is sign-extended from bit 31 up to XLEN.
  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.opcode = in_inst[6:0];
    dec.funct3 = in_inst[14:12];
    dec.funct7 = in_inst[31:25];
    dec.rs1    = in_inst[15 +: RA_W];
    dec.rs2    = in_inst[20 +: RA_W];
    dec.rd     = in_inst[7 +: RA_W];
    dec.imm    = XLEN'($signed(imm32));
    dec.fmt    = fmt;
  end

  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  // A flush cycle neither accepts nor consumes.
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Buffer storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
    end
  end

  assign out_pc     = mem[rd_ptr].pc;
  assign out_opcode = mem[rd_ptr].opcode;
  assign out_funct3 = mem[rd_ptr].funct3;
  assign out_funct7 = mem[rd_ptr].funct7;
  assign out_rs1    = mem[rd_ptr].rs1;
  assign out_rs2    = mem[rd_ptr].rs2;
  assign out_rd     = mem[rd_ptr].rd;
  assign out_imm    = mem[rd_ptr].imm;
  assign out_fmt    = mem[rd_ptr].fmt;

`ifdef YSYX_25020047_IDU_ILLEGAL_EN
  logic ill_mem [DEPTH];
  logic ill;

  // Illegal: non-32-bit encoding, unknown opcode, or (RV32E) a used register index >= 16.
  always_comb begin
    ill = (in_inst[1:0] != 2'b11) || (fmt == FMT_N);
    if (RA_W == 4) begin
      unique case (fmt)
        FMT_R:        ill = ill || in_inst[19] || in_inst[24] || in_inst[11];
        FMT_I:        ill = ill || in_inst[19] || in_inst[11];
        FMT_S, FMT_B: ill = ill || in_inst[19] || in_inst[24];
        FMT_U, FMT_J: ill = ill || in_inst[11];
        default:      ill = 1'b1;
      endcase
    end
  end

  // Flag stored alongside its entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) ill_mem[i] <= 1'b0;
    end else if (push) begin
      ill_mem[wr_ptr] <= ill;
    end
  end

  assign out_illegal = ill_mem[rd_ptr];
`else
  assign out_illegal = 1'b0;
`endif

endmodule
